// File: rtl/simpleuart_pkg.sv
// Shared types and constants for the simpleuart receive path.
// Holds the receiver FSM state enum, the data-bit count, the divider floor and a parity helper.
package simpleuart_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int MIN_DIV        = 4;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE,
    PARITY
  } rx_state_e;

  // Returns 1 when data plus parity bit do not give even parity.
  function automatic logic parity_bad(
    input logic [UART_DATA_BITS-1:0] d,
    input logic                      p
  );
    return ^{d, p};
  endfunction

endpackage

// File: rtl/simpleuart_rx_fifo_mem.sv
// Synchronous byte FIFO with a registered head entry.
// Ports: clk/reset, push+wr_data, pop, rd_data/rd_valid, level, drop (push lost to full).
module simpleuart_rx_fifo_mem
  import simpleuart_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic [UART_DATA_BITS-1:0] wr_data,
  input  logic                      pop,
  output logic [UART_DATA_BITS-1:0] rd_data,
  output logic                      rd_valid,
  output logic [DEPTH_LOG2:0]       level,
  output logic                      drop
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [UART_DATA_BITS-1:0] mem_q [DEPTH];
  logic [DEPTH_LOG2:0]       wr_q, wr_d;
  logic [DEPTH_LOG2:0]       rd_q, rd_d;
  logic [UART_DATA_BITS-1:0] head_q, head_d;
  logic                      empty, full;
  logic                      push_ok, pop_ok;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[DEPTH_LOG2] != rd_q[DEPTH_LOG2]) &&
                 (wr_q[DEPTH_LOG2-1:0] == rd_q[DEPTH_LOG2-1:0]);

  assign pop_ok  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_ok = push & (~full | pop_ok);
  assign drop    = push & full & ~pop_ok;

  always_comb begin
    wr_d   = wr_q + {{DEPTH_LOG2{1'b0}}, push_ok};
    rd_d   = rd_q + {{DEPTH_LOG2{1'b0}}, pop_ok};
    head_d = head_q;
    if (pop_ok || (push_ok && empty)) begin
      // New head is the incoming byte when it lands exactly at the read slot.
      if (push_ok && (rd_d == wr_q)) begin
        head_d = wr_data;
      end else begin
        head_d = mem_q[rd_d[DEPTH_LOG2-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q   <= '0;
      rd_q   <= '0;
      head_q <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      head_q <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_q[DEPTH_LOG2-1:0]] <= wr_data;
    end
  end

  assign rd_data  = head_q;
  assign rd_valid = ~empty;
  assign level    = wr_q - rd_q;

endmodule

// File: rtl/simpleuart_rx_fifo.sv
// 8N1 UART receiver feeding a byte FIFO drained by valid/ready; sticky overflow/frame_err flags.
// Ports: clk, reset, ser_rx, cfg_div, rd_data/rd_valid/rd_ready, level, overflow, frame_err, clr_err.
// Define UART_RX_PARITY_EN to add an even parity bit and the parity_err output.
module simpleuart_rx_fifo
  import simpleuart_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ser_rx,
  input  logic [DIV_WIDTH-1:0] cfg_div,
  output logic [7:0]           rd_data,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [DEPTH_LOG2:0]  level,
  output logic                 overflow,
  output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  input  logic                 clr_err
);

  logic                      sync1_q, rx_s, prev_q;
  rx_state_e                 state_q, state_d;
  logic [DIV_WIDTH-1:0]      div_q, div_d, div_in;
  logic [DIV_WIDTH-1:0]      cnt_q, cnt_d;
  logic [2:0]                idx_q, idx_d;
  logic [UART_DATA_BITS-1:0] data_q, data_d;
  logic                      overflow_q, overflow_d;
  logic                      frame_err_q, frame_err_d;
  logic                      push, drop, fe_set;
  logic                      expired;
`ifdef UART_RX_PARITY_EN
  logic                      par_q, par_d;
  logic                      parity_err_q, parity_err_d;
  logic                      pe_set;
`endif

  assign expired = (cnt_q == '0);
  // A divider below the floor cannot place a mid-bit sample; clamp it.
  assign div_in  = (cfg_div < DIV_WIDTH'(MIN_DIV)) ?
                   DIV_WIDTH'(MIN_DIV) : cfg_div;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    data_d  = data_q;
    push    = 1'b0;
    fe_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    pe_set  = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (prev_q && !rx_s) begin
          state_d = START;
          div_d   = div_in;
          cnt_d   = div_in >> 1;
        end
      end
      START: begin
        if (!expired) begin
          cnt_d = cnt_q - 1'b1;
        end else if (rx_s) begin
          state_d = IDLE;
        end else begin
          state_d = DATA;
          cnt_d   = div_q;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (!expired) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          data_d[idx_q] = rx_s;
          cnt_d         = div_q;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (!expired) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          par_d   = rx_s;
          cnt_d   = div_q;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (!expired) begin
          cnt_d = cnt_q - 1'b1;
        end else if (rx_s) begin
          state_d = IDLE;
`ifdef UART_RX_PARITY_EN
          if (parity_bad(data_q, par_q)) begin
            pe_set = 1'b1;
          end else begin
            push = 1'b1;
          end
`else
          push = 1'b1;
`endif
        end else begin
          fe_set  = 1'b1;
          state_d = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sticky flags: a set in the same cycle as clr_err wins.
  always_comb begin
    overflow_d   = (clr_err ? 1'b0 : overflow_q) | drop;
    frame_err_d  = (clr_err ? 1'b0 : frame_err_q) | fe_set;
`ifdef UART_RX_PARITY_EN
    parity_err_d = (clr_err ? 1'b0 : parity_err_q) | pe_set;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= 1'b1;
      rx_s        <= 1'b1;
      prev_q      <= 1'b1;
      state_q     <= IDLE;
      div_q       <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      data_q      <= '0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sync1_q     <= ser_rx;
      rx_s        <= sync1_q;
      prev_q      <= rx_s;
      state_q     <= state_d;
      div_q       <= div_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      data_q      <= data_d;
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      par_q        <= par_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign parity_err = parity_err_q;
`endif

  simpleuart_rx_fifo_mem #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_mem (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .wr_data  (data_q),
    .pop      (rd_ready),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .level    (level),
    .drop     (drop)
  );

  assign overflow  = overflow_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_simpleuart_rx_fifo.sv
// Directed bench for simpleuart_rx_fifo: framing, glitch, overflow,
// full-with-pop, break and mid-frame reset.
module tb_simpleuart_rx_fifo;

  localparam int BIT = 106;
  localparam int FRAME = 10 * BIT;

  logic        clk = 1'b0;
  logic        reset;
  logic        ser_rx;
  logic [15:0] cfg_div;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        rd_ready;
  logic [4:0]  level;
  logic        overflow;
  logic        frame_err;
  logic        clr_err;
`ifdef UART_RX_PARITY_EN
  logic        parity_err;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  simpleuart_rx_fifo dut (
    .clk       (clk),
    .reset     (reset),
    .ser_rx    (ser_rx),
    .cfg_div   (cfg_div),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .level     (level),
    .overflow  (overflow),
    .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .clr_err   (clr_err)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic fbit(input logic [7:0] b, input int c);
    int k;
    k = c / BIT;
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    return 1'b1;
  endfunction

  // Drives one frame; c indexes clocks from the edge before the start bit.
  // rd_ready is high across edge pop_at; reset fires at abort_at.
  task automatic send(input logic [7:0] b, input int pop_at,
                      input int abort_at, output int rise);
    logic pv;
    rise = -1;
    pv = rd_valid;
    for (int c = 0; c < FRAME; c++) begin
      @(posedge clk);
      #1;
      if (rd_valid && !pv && rise < 0) rise = c;
      pv = rd_valid;
      rd_ready = (c == pop_at - 1);
      if (c == abort_at) begin
        reset = 1'b1;
        ser_rx = 1'b1;
        return;
      end
      ser_rx = fbit(b, c);
    end
  endtask

  task automatic send_b(input logic [7:0] b);
    int r;
    send(b, -1, -1, r);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
    check(tag, 32'({rd_valid, rd_data}), 32'({1'b1, exp}));
    rd_ready = 1'b1;
    @(posedge clk);
    #1;
    rd_ready = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    check({tag, "_valid"}, 32'(rd_valid), 32'(0));
    check({tag, "_data"}, 32'(rd_data), 32'(0));
    check({tag, "_level"}, 32'(level), 32'(0));
    check({tag, "_ovf"}, 32'(overflow), 32'(0));
    check({tag, "_ferr"}, 32'(frame_err), 32'(0));
  endtask

  initial begin
    int r;
    reset = 1'b1;
    ser_rx = 1'b1;
    rd_ready = 1'b0;
    clr_err = 1'b0;
    cfg_div = 16'd106;
    idle(3);
    chk_reset("rst");
    reset = 1'b0;
    idle(5);

    // Stop sample lands on edge 1020 of the frame.
    send(8'h41, -1, -1, r);
    check("lat", 32'(r), 32'd1020);
    check("a_valid", 32'(rd_valid), 32'd1);
    check("a_data", 32'(rd_data), 32'h41);
    check("a_level", 32'(level), 32'd1);
    rd_ready = 1'b1;
    idle(1);
    rd_ready = 1'b0;
    check("a_pop_lvl", 32'(level), 32'd0);
    check("a_pop_vld", 32'(rd_valid), 32'd0);

    @(posedge clk);
    #1 ser_rx = 1'b0;
    idle(20);
    ser_rx = 1'b1;
    idle(300);
    check("gl_level", 32'(level), 32'd0);
    check("gl_valid", 32'(rd_valid), 32'd0);
    check("gl_ferr", 32'(frame_err), 32'd0);

    for (int i = 0; i < 17; i++) send_b(8'(i));
    check("ov_level", 32'(level), 32'd16);
    check("ov_flag", 32'(overflow), 32'd1);
    for (int i = 0; i < 16; i++)
      pop_chk($sformatf("ov_pop%0d", i), 8'(i));
    check("ov_empty", 32'(level), 32'd0);
    check("ov_held", 32'(overflow), 32'd1);
    clr_err = 1'b1;
    idle(1);
    clr_err = 1'b0;
    check("ov_clr", 32'(overflow), 32'd0);

    for (int i = 0; i < 16; i++) send_b(8'(8'h80 + i));
    check("fp_full", 32'(level), 32'd16);
    send(8'h90, 1020, -1, r);
    check("fp_level", 32'(level), 32'd16);
    check("fp_ovf", 32'(overflow), 32'd0);
    for (int i = 1; i <= 16; i++)
      pop_chk($sformatf("fp_pop%0d", i), 8'(8'h80 + i));
    check("fp_empty", 32'(level), 32'd0);

    // Break: clr_err meets the stop-sample error event, then is reissued.
    @(posedge clk);
    #1 ser_rx = 1'b0;
    for (int c = 1; c < 30 * BIT; c++) begin
      @(posedge clk);
      #1;
      clr_err = (c == 1019) || (c == 1600);
      if (c == 1020) check("br_setwin", 32'(frame_err), 32'd1);
      if (c == 1500) check("br_level", 32'(level), 32'd0);
      if (c == 3000) check("br_once", 32'(frame_err), 32'd0);
    end
    clr_err = 1'b0;
    ser_rx = 1'b1;
    idle(50);
    check("br_after", 32'(frame_err), 32'd0);
    check("br_novld", 32'(rd_valid), 32'd0);
    send_b(8'h55);
    pop_chk("br_55", 8'h55);

    send_b(8'h5A);
    check("rs_pre", 32'(rd_data), 32'h5A);
    send(8'hA5, -1, 450, r);
    idle(2);
    chk_reset("mid");
    reset = 1'b0;
    idle(50);
    send_b(8'h3C);
    check("rs_level", 32'(level), 32'd1);
    pop_chk("rs_3c", 8'h3C);
    check("rs_end", 32'(level), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
